// File: rtl/alsu_pkg.sv
// Shared opcodes, flag bit positions, FSM states and per-beat tag payload for the ALSU arbiter.
package alsu_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 7;

    localparam logic [OP_W-1:0] OP_AND    = 3'b000;
    localparam logic [OP_W-1:0] OP_XOR    = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL    = 3'b011;
    localparam logic [OP_W-1:0] OP_SHIFT  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROTATE = 3'b101;

    localparam int unsigned FLAG_CIN     = 6;
    localparam int unsigned FLAG_SI      = 5;
    localparam int unsigned FLAG_SH_LEFT = 4;
    localparam int unsigned FLAG_RED_A   = 3;
    localparam int unsigned FLAG_RED_B   = 2;
    localparam int unsigned FLAG_PASS_A  = 1;
    localparam int unsigned FLAG_PASS_B  = 0;

    // Idle cycles drive AND of zeros, which also clears the ALSU output register.
    localparam logic [OP_W-1:0]   NOP_OPCODE = OP_AND;
    localparam logic [FLAG_W-1:0] NOP_FLAGS  = '0;

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0, err: 1'b0};

    // Opcodes 110/111, or a reduction request on anything but AND/XOR.
    function automatic logic cmd_err(input logic [OP_W-1:0] op, input logic [FLAG_W-1:0] flags);
        return (op[2] & op[1]) | ((flags[FLAG_RED_A] | flags[FLAG_RED_B]) & (op[2] | op[1]));
    endfunction

endpackage

// File: rtl/alsu_tag_pipe.sv
// Three-stage {valid, id, err} shift register mirroring the ALSU's fixed beat latency.
module alsu_tag_pipe
    import alsu_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid_c
);

    localparam int unsigned DEPTH = 3;

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage[0] <= TAG_NONE;
            stage[1] <= TAG_NONE;
            stage[2] <= TAG_NONE;
        end else begin
            stage[0] <= tag_in;
            stage[1] <= stage[0];
            stage[2] <= stage[1];
        end
    end

    assign tag_out     = stage[2];
    assign any_valid_c = stage[0].valid | stage[1].valid | stage[2].valid;

endmodule

// File: rtl/alsu_arbiter.sv
// Round-robin two-requester front end for the ALSU with lockable ownership for shift/rotate chains.
module alsu_arbiter
    import alsu_pkg::*;
#(
    parameter int unsigned BITS = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*OP_W-1:0]     req_opcode,
    input  logic [NREQ*BITS-1:0]     req_a,
    input  logic [NREQ*BITS-1:0]     req_b,
    input  logic [NREQ*FLAG_W-1:0]   req_flags,
    output logic [OP_W-1:0]          alsu_opcode,
    output logic [BITS-1:0]          alsu_a,
    output logic [BITS-1:0]          alsu_b,
    output logic [FLAG_W-1:0]        alsu_flags,
    input  logic [2*BITS-1:0]        alsu_out,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic                     rsp_err,
    output logic [2*BITS-1:0]        rsp_data,
    output logic                     busy
);

    arb_state_t        state, state_nx;
    logic              rr, rr_nx;
    logic              gid;
    logic [NREQ-1:0]   grant;
    logic [OP_W-1:0]   sel_opcode;
    logic [BITS-1:0]   sel_a, sel_b;
    logic [FLAG_W-1:0] sel_flags;
    tag_t              tag_in, tag_out;
    logic              tag_busy_c;

    // Grant selection and lock/round-robin bookkeeping.
    always_comb begin
        grant    = '0;
        state_nx = state;
        rr_nx    = rr;
        gid      = 1'b0;
        unique case (state)
            ST_OPEN:  grant = (req_valid == {NREQ{1'b1}}) ? (rr ? 2'b10 : 2'b01) : req_valid;
            ST_LOCK0: grant = {1'b0, req_valid[0]};
            ST_LOCK1: grant = {req_valid[1], 1'b0};
            default:  grant = '0;
        endcase
        gid = grant[1];
        if (|grant) begin
            rr_nx = ~gid;
            if (req_lock[gid]) begin
                state_nx = gid ? ST_LOCK1 : ST_LOCK0;
            end else begin
                state_nx = ST_OPEN;
            end
        end
    end

    always_comb begin
        sel_opcode = gid ? req_opcode[OP_W +: OP_W]     : req_opcode[0 +: OP_W];
        sel_a      = gid ? req_a[BITS +: BITS]          : req_a[0 +: BITS];
        sel_b      = gid ? req_b[BITS +: BITS]          : req_b[0 +: BITS];
        sel_flags  = gid ? req_flags[FLAG_W +: FLAG_W]  : req_flags[0 +: FLAG_W];
    end

    always_comb begin
        tag_in       = TAG_NONE;
        tag_in.valid = |grant;
        tag_in.id    = gid;
        tag_in.err   = (|grant) & cmd_err(sel_opcode, sel_flags);
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_OPEN;
            rr          <= 1'b0;
            alsu_opcode <= NOP_OPCODE;
            alsu_a      <= '0;
            alsu_b      <= '0;
            alsu_flags  <= NOP_FLAGS;
        end else begin
            state <= state_nx;
            rr    <= rr_nx;
            if (|grant) begin
                alsu_opcode <= sel_opcode;
                alsu_a      <= sel_a;
                alsu_b      <= sel_b;
                alsu_flags  <= sel_flags;
            end else begin
                alsu_opcode <= NOP_OPCODE;
                alsu_a      <= '0;
                alsu_b      <= '0;
                alsu_flags  <= NOP_FLAGS;
            end
        end
    end

    alsu_tag_pipe u_tag_pipe (
        .clk         (clk),
        .rstn        (rstn),
        .tag_in      (tag_in),
        .tag_out     (tag_out),
        .any_valid_c (tag_busy_c)
    );

    assign rsp_valid = tag_out.valid;
    assign rsp_id    = tag_out.id;
    assign rsp_err   = tag_out.err;
    assign rsp_data  = tag_out.valid ? alsu_out : '0;
    assign busy      = tag_busy_c | (state != ST_OPEN);

endmodule

// File: tb/tb_alsu_arbiter.sv
// Scoreboard bench: alsu_arbiter driving a behavioural ALSU (BITS=3, A priority, full adder on).
module tb_alsu_arbiter;
    import alsu_pkg::*;

    localparam int unsigned BITS = 3;
    localparam int unsigned OW   = 2 * BITS;

    localparam logic [6:0] F_NONE    = 7'b0000000;
    localparam logic [6:0] F_CIN     = 7'b1000000;
    localparam logic [6:0] F_PASSA   = 7'b0000010;
    localparam logic [6:0] F_REDA    = 7'b0001000;
    localparam logic [6:0] F_SHL_SI1 = 7'b0110000;
    localparam logic [6:0] F_SHL_SI0 = 7'b0010000;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req_valid, req_ready, req_lock;
    logic [5:0]        req_opcode;
    logic [2*BITS-1:0] req_a, req_b;
    logic [13:0]       req_flags;
    logic [2:0]        alsu_opcode;
    logic [BITS-1:0]   alsu_a, alsu_b;
    logic [6:0]        alsu_flags;
    logic [OW-1:0]     alsu_out;
    logic              rsp_valid, rsp_id, rsp_err, busy;
    logic [OW-1:0]     rsp_data;

    alsu_arbiter #(.BITS(BITS)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
        .alsu_opcode(alsu_opcode), .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_flags(alsu_flags),
        .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALSU: input register stage, then output register.
    logic [2:0]      x_op;
    logic [BITS-1:0] x_a, x_b;
    logic [6:0]      x_fl;

    function automatic logic [OW-1:0] alsu_eval(input logic [2:0] op, input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] b, input logic [6:0] f,
                                                input logic [OW-1:0] prev);
        if ((op[2] & op[1]) | ((f[3] | f[2]) & (op[2] | op[1]))) return '0;
        if (f[1]) return OW'(a);
        if (f[0]) return OW'(b);
        case (op)
            3'b000:  return f[3] ? OW'(&a) : (f[2] ? OW'(&b) : OW'(a & b));
            3'b001:  return f[3] ? OW'(^a) : (f[2] ? OW'(^b) : OW'(a ^ b));
            3'b010:  return OW'(a) + OW'(b) + OW'(f[6]);
            3'b011:  return OW'(a) * OW'(b);
            3'b100:  return f[4] ? {prev[OW-2:0], f[5]} : {f[5], prev[OW-1:1]};
            3'b101:  return f[4] ? {prev[OW-2:0], prev[OW-1]} : {prev[0], prev[OW-1:1]};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_op <= '0; x_a <= '0; x_b <= '0; x_fl <= '0; alsu_out <= '0;
        end else begin
            x_op <= alsu_opcode; x_a <= alsu_a; x_b <= alsu_b; x_fl <= alsu_flags;
            alsu_out <= alsu_eval(x_op, x_a, x_b, x_fl, alsu_out);
        end
    end

    // Reference model state and scoreboard.
    typedef struct {
        int   due;
        logic id;
        logic err;
        int   data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_rr, m_owner, m_prev;
    bit   started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic bit ref_err(input int op, input logic [6:0] f);
        return (op >= 6) || ((f[3] || f[2]) && op >= 2);
    endfunction

    function automatic int ref_result(input int op, input int a, input int b,
                                      input logic [6:0] f, input int prev);
        int full = (1 << BITS) - 1;
        int top  = 1 << (OW - 1);
        int md   = 1 << OW;
        if (ref_err(op, f)) return 0;
        if (f[1]) return a;
        if (f[0]) return b;
        case (op)
            0: begin
                if (f[3]) return (a == full) ? 1 : 0;
                if (f[2]) return (b == full) ? 1 : 0;
                return a & b;
            end
            1: begin
                if (f[3]) return $countones(a) % 2;
                if (f[2]) return $countones(b) % 2;
                return a ^ b;
            end
            2: return a + b + int'(f[6]);
            3: return a * b;
            4: return f[4] ? (prev * 2 + int'(f[5])) % md : prev / 2 + int'(f[5]) * top;
            5: return f[4] ? (prev * 2) % md + prev / top : prev / 2 + (prev % 2) * top;
            default: return 0;
        endcase
    endfunction

    // Monitor: every cycle the response pins must match the head of the queue or be idle.
    always @(negedge clk) begin
        if (started) begin
            if (!rstn) begin
                check("rsp_in_reset", rsp_valid == 1'b0 && rsp_data == '0, int'(rsp_valid), 0);
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", rsp_valid == 1'b1, int'(rsp_valid), 1);
                check("rsp_id",    rsp_id == mon_e.id, int'(rsp_id), int'(mon_e.id));
                check("rsp_err",   rsp_err == mon_e.err, int'(rsp_err), int'(mon_e.err));
                check("rsp_data",  int'(rsp_data) == mon_e.data, int'(rsp_data), mon_e.data);
            end else begin
                check("rsp_idle", rsp_valid == 1'b0 && rsp_data == '0,
                      int'({rsp_valid, rsp_data}), 0);
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rstn = 1'b0;
        req_valid = '0; req_lock = '0; req_opcode = '0; req_a = '0; req_b = '0; req_flags = '0;
        exp_q.delete();
        m_rr = 0; m_owner = -1; m_prev = 0;
        #1;
        check("reset_busy", busy == 1'b0, int'(busy), 0);
        check("reset_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data} == '0,
              int'({rsp_valid, rsp_id, rsp_err, rsp_data}), 0);
        check("reset_alsu", {alsu_opcode, alsu_a, alsu_b, alsu_flags} == '0,
              int'({alsu_opcode, alsu_a, alsu_b, alsu_flags}), 0);
        repeat (n - 1) @(posedge clk);
    endtask

    // One clock of stimulus; the model decides the winner, checks ready/busy, queues the response.
    task automatic step(input logic [1:0] v, input logic [1:0] lk,
                        input logic [2:0] op0, input logic [2:0] op1,
                        input logic [2:0] a0, input logic [2:0] b0,
                        input logic [2:0] a1, input logic [2:0] b1,
                        input logic [6:0] f0, input logic [6:0] f1);
        int g;
        logic [1:0] er;
        logic [2:0] op, a, b;
        logic [6:0] f;
        exp_t e;
        @(posedge clk); #1;
        rstn       = 1'b1;
        req_valid  = v;
        req_lock   = lk;
        req_opcode = {op1, op0};
        req_a      = {a1, a0};
        req_b      = {b1, b0};
        req_flags  = {f1, f0};
        #1;
        g = -1;
        if (m_owner >= 0) begin
            if (v[m_owner]) g = m_owner;
        end else if (v == 2'b11) g = m_rr;
        else if (v[0]) g = 0;
        else if (v[1]) g = 1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready == er, int'(req_ready), int'(er));
        check("busy", busy == ((exp_q.size() != 0) || (m_owner >= 0)), int'(busy),
              int'((exp_q.size() != 0) || (m_owner >= 0)));
        if (g >= 0) begin
            op = (g == 1) ? op1 : op0;
            a  = (g == 1) ? a1  : a0;
            b  = (g == 1) ? b1  : b0;
            f  = (g == 1) ? f1  : f0;
            e.due  = cyc + 3;
            e.id   = g[0];
            e.err  = ref_err(int'(op), f);
            e.data = ref_result(int'(op), int'(a), int'(b), f, m_prev);
            exp_q.push_back(e);
            m_prev  = e.data;
            m_rr    = 1 - g;
            m_owner = lk[g] ? g : -1;
        end else begin
            m_prev = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rv, rl;
        logic [2:0] ro0, ro1, ra0, rb0, ra1, rb1;
        logic [6:0] rf0, rf1;
        rstn = 1'b1;
        req_valid = '0; req_lock = '0; req_opcode = '0; req_a = '0; req_b = '0; req_flags = '0;
        m_rr = 0; m_owner = -1; m_prev = 0;
        do_reset(3);
        started = 1'b1;

        // Contention from the first cycle after release, then alternation.
        step(2'b11, 2'b00, OP_MUL, OP_XOR, 3'd7, 3'd7, 3'd5, 3'd3, F_NONE, F_NONE);
        step(2'b10, 2'b00, OP_MUL, OP_XOR, 3'd7, 3'd7, 3'd5, 3'd3, F_NONE, F_NONE);
        repeat (4) step(2'b11, 2'b00, OP_ADD, OP_AND, 3'd1, 3'd2, 3'd6, 3'd3, F_NONE, F_NONE);

        // ADD with carry in.
        step(2'b01, 2'b00, OP_ADD, OP_AND, 3'd3, 3'd4, 3'd0, 3'd0, F_CIN, F_NONE);
        step(2'b00, 2'b00, OP_AND, OP_AND, 3'd0, 3'd0, 3'd0, 3'd0, F_NONE, F_NONE);

        // Locked shift chain from requester 1 with requester 0 waiting.
        step(2'b11, 2'b10, OP_ADD, OP_AND,   3'd1, 3'd1, 3'd5, 3'd0, F_NONE, F_PASSA);
        step(2'b11, 2'b10, OP_ADD, OP_SHIFT, 3'd1, 3'd1, 3'd0, 3'd0, F_NONE, F_SHL_SI1);
        step(2'b11, 2'b00, OP_ADD, OP_SHIFT, 3'd1, 3'd1, 3'd0, 3'd0, F_NONE, F_SHL_SI0);
        step(2'b11, 2'b00, OP_ADD, OP_AND,   3'd1, 3'd1, 3'd0, 3'd0, F_NONE, F_NONE);

        // Invalid commands.
        step(2'b01, 2'b00, 3'b110, OP_AND, 3'd7, 3'd7, 3'd0, 3'd0, F_NONE, F_NONE);
        step(2'b01, 2'b00, OP_ADD, OP_AND, 3'd5, 3'd2, 3'd0, 3'd0, F_REDA, F_NONE);

        // Locked owner idles between two shifts; requester 1 is held off during the gap.
        step(2'b01, 2'b01, OP_AND,   OP_AND, 3'd5, 3'd0, 3'd0, 3'd0, F_PASSA,   F_NONE);
        step(2'b01, 2'b01, OP_SHIFT, OP_AND, 3'd0, 3'd0, 3'd0, 3'd0, F_SHL_SI1, F_NONE);
        step(2'b10, 2'b00, OP_AND,   OP_XOR, 3'd0, 3'd0, 3'd1, 3'd1, F_NONE,    F_NONE);
        step(2'b01, 2'b00, OP_SHIFT, OP_AND, 3'd0, 3'd0, 3'd0, 3'd0, F_SHL_SI1, F_NONE);
        repeat (3) step(2'b00, 2'b00, OP_AND, OP_AND, 3'd0, 3'd0, 3'd0, 3'd0, F_NONE, F_NONE);

        // Reset with two beats in flight, then requester 1 alone right after release.
        step(2'b01, 2'b00, OP_ADD, OP_AND, 3'd2, 3'd2, 3'd0, 3'd0, F_NONE, F_NONE);
        step(2'b10, 2'b00, OP_AND, OP_XOR, 3'd0, 3'd0, 3'd6, 3'd1, F_NONE, F_NONE);
        do_reset(2);
        step(2'b10, 2'b00, OP_AND, OP_XOR, 3'd0, 3'd0, 3'd1, 3'd2, F_NONE, F_NONE);

        // Randomized traffic, with one reset in the middle.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset(1);
            rv  = {2'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) != 0)} & 2'b11;
            rv  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            rl  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            ro0 = 3'($urandom_range(0, 7));
            ro1 = 3'($urandom_range(0, 7));
            ra0 = 3'($urandom); rb0 = 3'($urandom);
            ra1 = 3'($urandom); rb1 = 3'($urandom);
            rf0 = 7'($urandom);
            rf1 = 7'($urandom);
            if ($urandom_range(0, 5) != 0) rf0[3:0] = 4'b0000;
            if ($urandom_range(0, 5) != 0) rf1[3:0] = 4'b0000;
            step(rv, rl, ro0, ro1, ra0, rb0, ra1, rb1, rf0, rf1);
        end

        repeat (5) step(2'b00, 2'b00, OP_AND, OP_AND, 3'd0, 3'd0, 3'd0, 3'd0, F_NONE, F_NONE);
        @(negedge clk); #1;
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
